// File: rtl/bus_copy_dma.sv
// bus_copy_dma: word-by-word memory-to-memory copy engine acting as initiator
// on a PicoRV32 native memory bus, with abort, alignment check and bus timeout.
module bus_copy_dma #(
    parameter int LEN_BITS       = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [LEN_BITS-1:0] len_words,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                aborted,
    output logic [LEN_BITS-1:0] words_done,
    output logic                mem_valid,
    output logic                mem_instr,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_ready,
    input  logic [31:0]         mem_rdata
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;
    state_t              state_q, state_d;
    logic [31:0]         src_q, src_d, dst_q, dst_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [LEN_BITS-1:0] len_q, len_d, words_q, words_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic                abt_q, abt_d, pend_q, pend_d;
    logic                stall, expire, rd, last;
    assign stall      = valid_q && !mem_ready;
    assign expire     = stall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign rd         = state_q == READ;
    assign last       = (words_q + LEN_BITS'(1)) == len_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign error      = err_q;
    assign aborted    = abt_q;
    assign words_done = words_q;
    assign mem_valid  = valid_q;
    assign mem_instr  = 1'b0;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        words_d = words_q;
        wstrb_d = wstrb_q;
        valid_d = valid_q;
        err_d   = err_q;
        abt_d   = abt_q;
        done_d  = 1'b0;
        pend_d  = pend_q || (abort && state_q != IDLE);
        tmo_d   = (stall && !expire) ? tmo_q + TW'(1) : '0;
        case (state_q)
            IDLE: if (start) begin
                src_d   = src_addr;
                dst_d   = dst_addr;
                len_d   = len_words;
                words_d = '0;
                err_d   = 1'b0;
                abt_d   = 1'b0;
                pend_d  = 1'b0;
                if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (len_words == '0) begin
                    state_d = FINISH;
                end else begin
                    state_d = READ;
                    valid_d = 1'b1;
                    addr_d  = src_addr;
                    wstrb_d = 4'h0;
                end
            end
            // valid low here is the mandatory idle gap; the next transfer is issued from it
            READ, WRITE: if (!valid_q) begin
                if (pend_q || abort) begin
                    abt_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = rd ? src_q : dst_q;
                    wstrb_d = rd ? 4'h0 : 4'hF;
                end
            end else if (expire) begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                state_d = FINISH;
            end else if (mem_ready) begin
                valid_d = 1'b0;
                if (rd) begin
                    wdata_d = mem_rdata;
                    src_d   = src_q + 32'd4;
                    state_d = WRITE;
                end else begin
                    dst_d   = dst_q + 32'd4;
                    words_d = words_q + LEN_BITS'(1);
                    state_d = last ? FINISH : READ;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            words_q <= '0;
            wstrb_q <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abt_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            words_q <= words_d;
            wstrb_q <= wstrb_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            abt_q   <= abt_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_bus_copy_dma.sv
// tb_bus_copy_dma: directed bench for bus_copy_dma with a behavioural bus
// responder (programmable ready latency) and a bus protocol monitor.
module tb_bus_copy_dma;
    logic        clk = 1'b0;
    logic        resetn, start, abort;
    logic [31:0] src_addr, dst_addr;
    logic [9:0]  len_words;
    logic        busy, done, error, aborted;
    logic [9:0]  words_done;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int total = 0, passed = 0;
    int rd_dly = 0, wr_dly = 0, wcnt = 0;
    bit never = 1'b0;
    logic [31:0] la[$], ld[$];
    logic [3:0]  ls[$];
    int done_cnt = 0, vcyc = 0, unstable = 0, gap_err = 0, instr_cnt = 0;
    int run = 0, run_last = 0, wr_run_last = 0;
    logic        pv = 1'b0, pacc = 1'b0;
    logic [67:0] pvec = '0;
    logic [3:0]  pstrb = '0;

    bus_copy_dma #(.LEN_BITS(10), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .error(error), .aborted(aborted),
        .words_done(words_done), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Responder: raises ready for one cycle after the programmed wait and logs the transfer.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            wcnt      <= 0;
        end else if (mem_valid && !mem_ready && !never) begin
            if (wcnt >= ((mem_wstrb != 4'h0) ? wr_dly : rd_dly)) begin
                mem_ready <= 1'b1;
                wcnt      <= 0;
                mem_rdata <= 32'hC0DE_0000 | {16'h0, mem_addr[15:0]};
                la.push_back(mem_addr);
                ld.push_back(mem_wdata);
                ls.push_back(mem_wstrb);
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            mem_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_instr) instr_cnt <= instr_cnt + 1;
        if (mem_valid && pacc) gap_err <= gap_err + 1;
        if (mem_valid) begin
            vcyc <= vcyc + 1;
            run  <= run + 1;
            if (pv && {mem_addr, mem_wdata, mem_wstrb} != pvec) unstable <= unstable + 1;
        end else if (pv) begin
            run_last <= run;
            if (pstrb != 4'h0) wr_run_last <= run;
            run <= 0;
        end
        pv    <= mem_valid;
        pvec  <= {mem_addr, mem_wdata, mem_wstrb};
        pstrb <= mem_wstrb;
        pacc  <= mem_valid && mem_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_rd(input string tag, input int idx, input logic [31:0] addr);
        chk({tag, "_addr"}, la[idx], addr);
        chk({tag, "_strb"}, {28'h0, ls[idx]}, 32'h0);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_addr"}, la[idx], addr);
        chk({tag, "_data"}, ld[idx], data);
        chk({tag, "_strb"}, {28'h0, ls[idx]}, 32'hF);
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, {31'h0, done}, 32'h1);
    endtask

    initial begin
        int base, d0, v0, n;
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len_words = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, mem_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_err", {31'h0, error}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wstrb", {28'h0, mem_wstrb}, 0);
        chk("rst_words", {22'h0, words_done}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // three-word copy, one-cycle responder latency
        base = la.size(); d0 = done_cnt;
        do_start(32'h100, 32'h200, 10'd3);
        chk("c3_valid_next", {31'h0, mem_valid}, 1);
        chk("c3_addr0", mem_addr, 32'h100);
        chk("c3_busy", {31'h0, busy}, 1);
        wait_done("c3", 100);
        @(negedge clk);
        chk("c3_done_once", done_cnt - d0, 1);
        chk("c3_nxfer", la.size() - base, 6);
        chk_rd("c3_r0", base, 32'h100);
        chk_wr("c3_w0", base + 1, 32'h200, 32'hC0DE_0100);
        chk_rd("c3_r1", base + 2, 32'h104);
        chk_wr("c3_w1", base + 3, 32'h204, 32'hC0DE_0104);
        chk_rd("c3_r2", base + 4, 32'h108);
        chk_wr("c3_w2", base + 5, 32'h208, 32'hC0DE_0108);
        chk("c3_words", {22'h0, words_done}, 3);
        chk("c3_err", {31'h0, error}, 0);
        chk("c3_busy_end", {31'h0, busy}, 0);

        // empty copy and misaligned source: done two cycles after start, no bus traffic
        v0 = vcyc;
        do_start(32'h100, 32'h200, 10'd0);
        chk("z_valid", {31'h0, mem_valid}, 0);
        chk("z_done_early", {31'h0, done}, 0);
        @(negedge clk);
        chk("z_done", {31'h0, done}, 1);
        chk("z_err", {31'h0, error}, 0);
        do_start(32'h102, 32'h200, 10'd2);
        chk("m_done_early", {31'h0, done}, 0);
        @(negedge clk);
        chk("m_done", {31'h0, done}, 1);
        chk("m_err", {31'h0, error}, 1);
        @(negedge clk);
        chk("m_done_fall", {31'h0, done}, 0);
        chk("zm_no_valid", vcyc - v0, 0);

        // write stalled five cycles: request held stable for six valid cycles
        wr_dly = 4;
        base = la.size();
        do_start(32'h300, 32'h400, 10'd2);
        wait_done("st", 100);
        @(negedge clk);
        chk("st_wr_run", wr_run_last, 6);
        chk("st_nxfer", la.size() - base, 4);
        chk_wr("st_w0", base + 1, 32'h400, 32'hC0DE_0300);
        chk_wr("st_w1", base + 3, 32'h404, 32'hC0DE_0304);
        chk("st_words", {22'h0, words_done}, 2);
        chk("st_err", {31'h0, error}, 0);
        wr_dly = 0;

        // abort while idle does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("ai_busy", {31'h0, busy}, 0);
        chk("ai_aborted", {31'h0, aborted}, 0);

        // abort during the second read of a four-word copy
        rd_dly = 2;
        base = la.size();
        do_start(32'h500, 32'h600, 10'd4);
        n = 0;
        while (!(mem_valid && mem_wstrb == 4'h0 && la.size() == base + 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ab_in_rd2", mem_addr, 32'h504);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("ab", 100);
        chk("ab_nxfer", la.size() - base, 3);
        chk_rd("ab_r1", base + 2, 32'h504);
        chk("ab_aborted", {31'h0, aborted}, 1);
        chk("ab_words", {22'h0, words_done}, 1);
        chk("ab_err", {31'h0, error}, 0);
        rd_dly = 0;
        @(negedge clk);

        // address wrap past the top of the address space
        base = la.size();
        do_start(32'hFFFF_FFFC, 32'h10, 10'd2);
        wait_done("wr", 100);
        chk("wr_nxfer", la.size() - base, 4);
        chk_rd("wr_r0", base, 32'hFFFF_FFFC);
        chk_wr("wr_w0", base + 1, 32'h10, 32'hC0DE_FFFC);
        chk_rd("wr_r1", base + 2, 32'h0);
        chk_wr("wr_w1", base + 3, 32'h14, 32'hC0DE_0000);
        @(negedge clk);

        // responder never ready: timeout after eight valid cycles
        never = 1'b1;
        base = la.size();
        do_start(32'h700, 32'h800, 10'd2);
        chk("to_valid", {31'h0, mem_valid}, 1);
        wait_done("to", 40);
        @(negedge clk);
        chk("to_run", run_last, 8);
        chk("to_err", {31'h0, error}, 1);
        chk("to_words", {22'h0, words_done}, 0);
        chk("to_nxfer", la.size() - base, 0);
        never = 1'b0;

        // start while busy is ignored
        rd_dly = 3;
        base = la.size();
        do_start(32'h900, 32'hA00, 10'd2);
        @(negedge clk);
        src_addr = 32'hF00; dst_addr = 32'hF80; len_words = 10'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ig", 100);
        chk("ig_nxfer", la.size() - base, 4);
        chk_rd("ig_r0", base, 32'h900);
        chk_wr("ig_w0", base + 1, 32'hA00, 32'hC0DE_0900);
        chk_rd("ig_r1", base + 2, 32'h904);
        chk("ig_words", {22'h0, words_done}, 2);
        chk("ig_err", {31'h0, error}, 0);
        rd_dly = 0;
        @(negedge clk);

        // asynchronous reset during the second write
        wr_dly = 6;
        base = la.size();
        do_start(32'hB00, 32'hC00, 10'd2);
        n = 0;
        while (!(mem_valid && mem_wstrb == 4'hF && la.size() == base + 3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rw_pre_words", {22'h0, words_done}, 1);
        chk("rw_pre_addr", mem_addr, 32'hC04);
        #2 resetn = 1'b0;
        #1;
        chk("rw_valid", {31'h0, mem_valid}, 0);
        chk("rw_addr", mem_addr, 0);
        chk("rw_wdata", mem_wdata, 0);
        chk("rw_wstrb", {28'h0, mem_wstrb}, 0);
        chk("rw_busy", {31'h0, busy}, 0);
        chk("rw_words", {22'h0, words_done}, 0);
        chk("rw_flags", {29'h0, done, error, aborted}, 0);
        wr_dly = 0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rw_idle_busy", {31'h0, busy}, 0);
        chk("rw_idle_valid", {31'h0, mem_valid}, 0);

        chk("gap_violations", gap_err, 0);
        chk("unstable_req", unstable, 0);
        chk("instr_seen", instr_cnt, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bus_copy_dma.md
BUS_COPY_DMA -- requirements
Module: bus_copy_dma

Interface
REQ-001 SHALL have parameter LEN_BITS, default 10, width of the word-count input and counter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles mem_valid may wait for mem_ready.
REQ-003 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 SHALL have abort  input  1  request to stop after the in-flight transaction.
REQ-007 SHALL have src_addr, dst_addr  input  32 each  byte addresses of source and destination, sampled on start.
REQ-008 SHALL have len_words  input  LEN_BITS  number of 32-bit words to copy, sampled on start.
REQ-009 SHALL have busy  output  1  high from the cycle after accepted start until entering IDLE.
REQ-010 SHALL have done  output  1  one-cycle pulse on completion, abort or error.
REQ-011 SHALL have error, aborted  output  1 each  sticky status, cleared on the next accepted start.
REQ-012 SHALL have words_done  output  LEN_BITS  words fully written in the current/last copy.
REQ-013 SHALL have mem_valid, mem_instr  output  1 each; mem_addr, mem_wdata  output  32; mem_wstrb  output  4; mem_ready  input  1; mem_rdata  input  32 -- native PicoRV32 memory bus, this block as initiator.

Function
REQ-014 SHALL implement states IDLE, READ, WRITE, FINISH.
REQ-015 SHALL in IDLE on start=1: latch inputs, clear error/aborted/words_done, go to READ (len_words>0, aligned) so mem_valid is high the next cycle.
REQ-016 SHALL treat src_addr[1:0]!=0 or dst_addr[1:0]!=0 as error: no bus access, go to FINISH, error=1.
REQ-017 SHALL treat len_words=0 as empty copy: no bus access, go to FINISH, error=0.
REQ-018 SHALL in READ drive mem_valid=1, mem_addr=src+4*i, mem_wstrb=0, mem_instr=0.
REQ-019 SHALL capture mem_rdata on the edge where mem_valid&&mem_ready, deassert mem_valid that edge, and go to WRITE.
REQ-020 SHALL in WRITE drive mem_valid=1 the cycle after the read completes, with mem_addr=dst+4*i, mem_wdata=captured word, mem_wstrb=4'hF, mem_instr=0.
REQ-021 SHALL on write acceptance deassert mem_valid, increment words_done and i, then go to READ, or to FINISH when i reaches len_words.
REQ-022 SHALL hold mem_addr, mem_wdata, mem_wstrb stable while mem_valid=1 and mem_ready=0; mem_valid never withdrawn except by timeout or reset.
REQ-023 SHALL keep mem_valid low for at least one cycle between transactions (responder accepts on valid&&!ready).
REQ-024 SHALL compute addresses modulo 2^32 (wrap past 32'hFFFF_FFFC silently).
REQ-025 SHALL on abort (any cycle while busy): latch a pending flag; let the in-flight transaction complete; then go to FINISH with aborted=1 instead of issuing another transaction. An interrupted read is not written.
REQ-026 SHALL count cycles with mem_valid=1 and mem_ready=0; on reaching TIMEOUT_CYCLES drop mem_valid, set error=1, go to FINISH.
REQ-027 SHALL in FINISH pulse done=1 for exactly one cycle, then enter IDLE with busy=0.
REQ-028 SHALL ignore start while busy; abort in IDLE has no effect.
REQ-029 SHALL ignore mem_ready while mem_valid=0.

Reset
REQ-030 SHALL on resetn=0 immediately enter IDLE with mem_valid=0, mem_instr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, aborted=0, words_done=0, timeout counter=0.
REQ-031 SHALL, if reset occurs mid-transaction, abandon it without completion; after release, remain IDLE until start.

Verification
REQ-032 Copy src=0x0000_0100, dst=0x0000_0200, len=3, responder ready 1 cycle after valid -> reads 0x100/0x104/0x108 alternate with writes 0x200/0x204/0x208 (wstrb F, data matches), done pulse once, words_done=3, error=0.
REQ-033 len=0 and separately src=0x0000_0102 -> no mem_valid; done pulse 2 cycles after start; error 0 and 1 respectively.
REQ-034 Responder stalls write ready 5 cycles -> addr/wdata/wstrb constant for all 6 valid cycles; copy completes normally.
REQ-035 abort asserted during 2nd read of len=4 -> 2nd read completes, no 2nd write, done pulse, aborted=1, words_done=1.
REQ-036 TIMEOUT_CYCLES=8, responder never ready -> mem_valid falls after 8 cycles, error=1, done pulse; then start mid-copy ignored check, and resetn low during WRITE -> all outputs zero asynchronously.
